// File: rtl/spi_target_serdes.sv
// spi_target_serdes: SPI target serializer/deserializer, receiving end of the FCB SPI master link.
// Ports: Bus_CLK_i/RST_n_i clock and synchronous active-low reset; SPE_i enable;
//   CPOL_i/CPHA_i/LSBFE_i/SPI_Bit_Ctrl_i frame format, latched while idle;
//   SCK_i/SSn_i/MOSI_i async bus inputs; MISO_o/MISO_OEn_o serial output and its enable;
//   TX_Data_i/TX_Load_i/TX_Empty_o single-entry transmit holding register;
//   RX_Data_o/RX_Valid_o/RX_Ack_i single-entry receive register;
//   Err_Clr_i/Overrun_o/Underrun_o/Abort_o sticky error flags.
module spi_target_serdes #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] TX_IDLE_BYTE = 8'hFF
) (
  input  logic       Bus_CLK_i,
  input  logic       RST_n_i,
  input  logic       SPE_i,
  input  logic       CPOL_i,
  input  logic       CPHA_i,
  input  logic       LSBFE_i,
  input  logic [2:0] SPI_Bit_Ctrl_i,
  input  logic       SCK_i,
  input  logic       SSn_i,
  input  logic       MOSI_i,
  output logic       MISO_o,
  output logic       MISO_OEn_o,
  input  logic [7:0] TX_Data_i,
  input  logic       TX_Load_i,
  output logic       TX_Empty_o,
  output logic [7:0] RX_Data_o,
  output logic       RX_Valid_o,
  input  logic       RX_Ack_i,
  input  logic       Err_Clr_i,
  output logic       Overrun_o,
  output logic       Underrun_o,
  output logic       Abort_o
);
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, DONE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d, ssn_sync_q, ssn_sync_d, mosi_sync_q, mosi_sync_d;
  logic sck_h_q, sck_h_d, ssn_h_q, ssn_h_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
  logic [2:0] bits_q, bits_d, cnt_q, cnt_d;
  logic first_q, first_d, b2b_q, b2b_d, pend_q, pend_d, und_pend_q, und_pend_d;
  logic [7:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic empty_q, empty_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, und_q, und_d;
  logic abort_q, abort_d, oen_q, oen_d;
  logic sck_s, ssn_s, mosi_s, lead, trail, smp, shf, ssn_fall;
  logic upd, ovr_set, und_set, abort_set;
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ssn_s    = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign lead     = cpol_q ? (sck_h_q & ~sck_s) : (sck_s & ~sck_h_q);
  assign trail    = cpol_q ? (sck_s & ~sck_h_q) : (sck_h_q & ~sck_s);
  assign smp      = cpha_q ? trail : lead;
  assign shf      = cpha_q ? lead : trail;
  assign ssn_fall = ssn_h_q & ~ssn_s;
  assign MISO_o     = oen_q | (lsbfe_q ? tx_sr_q[0] : tx_sr_q[bits_q]);
  assign MISO_OEn_o = oen_q;
  assign TX_Empty_o = empty_q;
  assign RX_Data_o  = rx_data_q;
  assign RX_Valid_o = rx_valid_q;
  assign Overrun_o  = ovr_q;
  assign Underrun_o = und_q;
  assign Abort_o    = abort_q;
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK_i};
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], SSn_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI_i};
    sck_h_d     = sck_s;
    ssn_h_d     = ssn_s;
  end
  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsbfe_d    = lsbfe_q;
    bits_d     = bits_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    b2b_d      = b2b_q;
    pend_d     = pend_q;
    und_pend_d = und_pend_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    empty_d    = empty_q;
    oen_d      = oen_q;
    upd        = 1'b0;
    ovr_set    = 1'b0;
    und_set    = 1'b0;
    abort_set  = 1'b0;
    if (state_q == IDLE) begin
      cpol_d  = CPOL_i;
      cpha_d  = CPHA_i;
      lsbfe_d = LSBFE_i;
      bits_d  = SPI_Bit_Ctrl_i;
    end
    if (!SPE_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (ssn_fall) state_d = LOAD;
        LOAD: begin
          // A speculative back-to-back frame that never saw a clock edge is not an aborted frame.
          if (ssn_s) begin
            abort_set = ~b2b_q;
            state_d   = IDLE;
          end else begin
            tx_sr_d    = empty_q ? TX_IDLE_BYTE : hold_q;
            und_set    = empty_q & ~b2b_q;
            und_pend_d = empty_q & b2b_q;
            empty_d    = 1'b1;
            rx_sr_d    = '0;
            cnt_d      = '0;
            first_d    = cpha_q;
            oen_d      = 1'b0;
            state_d    = ACTIVE;
          end
        end
        ACTIVE: begin
          if (ssn_s) begin
            abort_set = ~b2b_q;
            state_d   = IDLE;
          end else begin
            // Underrun of a back-to-back frame is reported once the master actually clocks it.
            if (smp | shf) begin
              b2b_d      = 1'b0;
              und_pend_d = 1'b0;
              und_set    = und_pend_q;
            end
            if (smp) begin
              rx_sr_d = lsbfe_q ? (rx_sr_q | (8'(mosi_s) << cnt_q)) : {rx_sr_q[6:0], mosi_s};
              cnt_d   = cnt_q + 3'd1;
              if (cnt_q == bits_q) begin
                state_d = DONE;
                pend_d  = 1'b1;
              end
            end
            if (shf) begin
              first_d = 1'b0;
              if (!first_q) tx_sr_d = lsbfe_q ? {1'b0, tx_sr_q[7:1]} : {tx_sr_q[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          if (pend_q) begin
            pend_d    = 1'b0;
            upd       = 1'b1;
            rx_data_d = rx_sr_q;
            ovr_set   = rx_valid_q & ~RX_Ack_i;
          end
          if (ssn_s) state_d = IDLE;
          else if (cpha_q | shf) begin
            state_d = LOAD;
            b2b_d   = 1'b1;
          end
        end
      endcase
    end
    if (state_d == IDLE) begin
      oen_d      = 1'b1;
      b2b_d      = 1'b0;
      und_pend_d = 1'b0;
    end
    if (TX_Load_i) begin
      hold_d  = TX_Data_i;
      empty_d = 1'b0;
    end
    rx_valid_d = upd | (rx_valid_q & ~RX_Ack_i);
    ovr_d      = ovr_set | (ovr_q & ~Err_Clr_i);
    und_d      = und_set | (und_q & ~Err_Clr_i);
    abort_d    = abort_set | (abort_q & ~Err_Clr_i);
  end
  always_ff @(posedge Bus_CLK_i) begin
    if (!RST_n_i) begin
      state_q     <= IDLE;
      sck_sync_q  <= '1;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '1;
      sck_h_q     <= 1'b1;
      ssn_h_q     <= 1'b1;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      bits_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      b2b_q       <= 1'b0;
      pend_q      <= 1'b0;
      und_pend_q  <= 1'b0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      empty_q     <= 1'b1;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      abort_q     <= 1'b0;
      oen_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ssn_sync_q  <= ssn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_h_q     <= sck_h_d;
      ssn_h_q     <= ssn_h_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsbfe_q     <= lsbfe_d;
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      b2b_q       <= b2b_d;
      pend_q      <= pend_d;
      und_pend_q  <= und_pend_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      empty_q     <= empty_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      abort_q     <= abort_d;
      oen_q       <= oen_d;
    end
  end
endmodule

// File: tb/tb_spi_target_serdes.sv
// tb_spi_target_serdes: directed and randomized SPI master frames checked against a frame-level model.
module tb_spi_target_serdes;
  localparam int SYNC = 2;
  localparam int H = 4;
  logic clk = 1'b0, rst_n = 1'b0, spe = 1'b1, cpol_i = 1'b0, cpha_i = 1'b0, lsbfe_i = 1'b0;
  logic [2:0] bitctl = 3'd7;
  logic sck = 1'b0, ssn = 1'b1, mosi = 1'b1, miso, oen;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic tx_load = 1'b0, tx_empty, rx_valid, rx_ack = 1'b0, err_clr = 1'b0, ovr, und, abrt;
  int vectors = 0, miscompares = 0;
  bit cpol, cpha, lsbfe;
  int n;
  bit e_valid, e_ovr, e_und, e_abort, e_empty;
  logic [7:0] e_rx, e_hold;
  spi_target_serdes #(.SYNC_STAGES(SYNC), .TX_IDLE_BYTE(8'hFF)) dut (
    .Bus_CLK_i(clk), .RST_n_i(rst_n), .SPE_i(spe), .CPOL_i(cpol_i), .CPHA_i(cpha_i),
    .LSBFE_i(lsbfe_i), .SPI_Bit_Ctrl_i(bitctl), .SCK_i(sck), .SSn_i(ssn), .MOSI_i(mosi),
    .MISO_o(miso), .MISO_OEn_o(oen), .TX_Data_i(tx_data), .TX_Load_i(tx_load),
    .TX_Empty_o(tx_empty), .RX_Data_o(rx_data), .RX_Valid_o(rx_valid), .RX_Ack_i(rx_ack),
    .Err_Clr_i(err_clr), .Overrun_o(ovr), .Underrun_o(und), .Abort_o(abrt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic bit_at(input logic [7:0] v, input int nb, input bit lsb, input int i);
    return lsb ? v[i] : v[nb-1-i];
  endfunction
  function automatic logic [7:0] sent_word(input logic [7:0] v, input int nb, input bit lsb);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < nb; i++) w = {w[6:0], bit_at(v, nb, lsb, i)};
    return w;
  endfunction
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic cfg();
    bitctl = 3'(n - 1); cpol_i = cpol; cpha_i = cpha; lsbfe_i = lsbfe; sck = cpol;
    cyc(6);
  endtask
  task automatic load_tx(input logic [7:0] d);
    tx_data = d; tx_load = 1'b1; cyc(1); tx_load = 1'b0;
    e_empty = 1'b0; e_hold = d;
  endtask
  task automatic ack();
    rx_ack = 1'b1; cyc(1); rx_ack = 1'b0; e_valid = 1'b0;
  endtask
  task automatic clr();
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    e_ovr = 1'b0; e_und = 1'b0; e_abort = 1'b0;
  endtask
  task automatic m_start(output logic [7:0] etx);
    etx = e_empty ? 8'hFF : e_hold;
    if (e_empty) e_und = 1'b1;
    e_empty = 1'b1;
  endtask
  task automatic m_end(input logic [7:0] m);
    if (e_valid) e_ovr = 1'b1;
    e_valid = 1'b1;
    e_rx = m & (8'hFF >> (8 - n));
  endtask
  task automatic ss_low(input logic [7:0] m);
    if (!cpha) mosi = bit_at(m, n, lsbfe, 0);
    ssn = 1'b0;
    cyc(8);
  endtask
  task automatic ss_high();
    ssn = 1'b1; mosi = 1'b1;
    cyc(8);
  endtask
  task automatic shift_bits(input logic [7:0] m, input int k, input logic nxt, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < k; i++) begin
      if (!cpha) begin
        got = {got[6:0], miso}; sck = ~cpol; cyc(H);
        sck = cpol; mosi = (i < n - 1) ? bit_at(m, n, lsbfe, i + 1) : nxt; cyc(H);
      end else begin
        sck = ~cpol; mosi = bit_at(m, n, lsbfe, i); cyc(H);
        got = {got[6:0], miso}; sck = cpol; cyc(H);
      end
    end
  endtask
  task automatic chk_state(input string tag);
    chk({tag, ".rx_data"}, rx_data, e_rx);
    chk({tag, ".rx_valid"}, 8'(rx_valid), 8'(e_valid));
    chk({tag, ".tx_empty"}, 8'(tx_empty), 8'(e_empty));
    chk({tag, ".overrun"}, 8'(ovr), 8'(e_ovr));
    chk({tag, ".underrun"}, 8'(und), 8'(e_und));
    chk({tag, ".abort"}, 8'(abrt), 8'(e_abort));
    chk({tag, ".miso_oen"}, 8'(oen), 8'd1);
    chk({tag, ".miso_idle"}, 8'(miso), 8'd1);
  endtask
  task automatic frame1(input string tag, input bit ld, input logic [7:0] tx, input logic [7:0] m);
    logic [7:0] got, etx;
    cfg();
    if (ld) load_tx(tx);
    m_start(etx);
    ss_low(m);
    shift_bits(m, n, 1'b1, got);
    ss_high();
    m_end(m);
    chk({tag, ".miso"}, got, sent_word(etx, n, lsbfe));
    chk_state(tag);
  endtask
  task automatic model_reset();
    e_valid = 0; e_ovr = 0; e_und = 0; e_abort = 0; e_empty = 1; e_rx = 8'h00; e_hold = 8'h00;
  endtask
  initial begin
    logic [7:0] g1, g2, e1, e2, rtx, rm;
    int w;
    model_reset();
    cyc(3);
    chk_state("reset");
    rst_n = 1'b1;
    cyc(4);
    cpol = 0; cpha = 0; lsbfe = 0; n = 8;
    frame1("mode0_msb", 1'b1, 8'hA5, 8'h3C);
    for (int md = 1; md < 4; md++) begin
      ack();
      cpol = md[1]; cpha = md[0]; lsbfe = 1; n = 8;
      frame1($sformatf("mode%0d_lsb", md), 1'b1, 8'h81, 8'h5A);
    end
    ack();
    cpol = 0; cpha = 0; lsbfe = 0; n = 4;
    frame1("n4_underrun", 1'b0, 8'h00, 8'h0B);
    clr();
    chk("n4_clr.underrun", 8'(und), 8'd0);
    ack();
    n = 8;
    cfg();
    load_tx(8'h5E);
    m_start(e1);
    ss_low(8'h11);
    shift_bits(8'h11, 8, bit_at(8'h22, 8, 1'b0, 0), g1);
    m_end(8'h11);
    m_start(e2);
    shift_bits(8'h22, 8, 1'b1, g2);
    ss_high();
    m_end(8'h22);
    chk("b2b.miso1", g1, sent_word(e1, 8, 1'b0));
    chk("b2b.miso2", g2, sent_word(e2, 8, 1'b0));
    chk_state("b2b");
    clr();
    chk("b2b_clr.overrun", 8'(ovr), 8'd0);
    ack();
    rtx = 8'($urandom);
    rm = 8'($urandom);
    cfg();
    load_tx(rtx);
    m_start(e1);
    ss_low(rm);
    shift_bits(rm, 5, 1'b1, g1);
    ssn = 1'b1;
    w = 0;
    while (oen !== 1'b1 && w < SYNC + 2) begin
      cyc(1);
      w++;
    end
    chk("abort.oen_latency", 8'(oen), 8'd1);
    cyc(8);
    e_abort = 1'b1;
    chk("abort.miso", g1, sent_word(rtx, 8, 1'b0) >> 3);
    chk_state("abort");
    clr();
    cfg();
    load_tx(8'h96);
    m_start(e1);
    ss_low(8'h77);
    shift_bits(8'h77, 3, 1'b1, g1);
    rst_n = 1'b0;
    cyc(1);
    model_reset();
    chk_state("midframe_reset");
    rst_n = 1'b1; ssn = 1'b1; sck = cpol; mosi = 1'b1;
    cyc(8);
    frame1("post_reset", 1'b1, 8'h4D, 8'hC3);
    for (int r = 0; r < 16; r++) begin
      cpol = 1'($urandom); cpha = 1'($urandom); lsbfe = 1'($urandom);
      n = int'($urandom_range(1, 8));
      if ($urandom_range(0, 3) != 0) ack();
      if ($urandom_range(0, 3) == 0) clr();
      frame1($sformatf("rand%0d", r), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
